imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 32, is the number of instruction-memory words the loader may write.
REQ-002 Parameter AW, default 6, is the width of the instruction-memory word address.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  is the asynchronous, active-low reset.
REQ-005 start  input  1  is a load request pulse; it is sampled only in IDLE, DONE or ERR.
REQ-006 in_valid  input  1  marks a byte offered on in_data.
REQ-007 in_data  input  8  is the byte-stream payload.
REQ-008 in_ready  output  1  means the loader accepts a byte; a byte transfers when in_valid and in_ready are both 1.
REQ-009 imem_we  output  1  is the instruction-memory write enable, a one-cycle pulse per word.
REQ-010 imem_a  output  AW  is the instruction-memory word address.
REQ-011 imem_wd  output  32  is the instruction-memory write data.
REQ-012 cpu_reset  output  1  is active high and holds the MIPS core in reset while no valid image is loaded.
REQ-013 busy  output  1  is 1 in LEN, DATA, WRITE and CSUM.
REQ-014 done  output  1  is 1 in DONE.
REQ-015 err  output  1  is 1 in ERR.

Function
REQ-016 The state machine SHALL have the states IDLE, LEN, DATA, WRITE, CSUM, DONE and ERR.
REQ-017 IDLE, DONE or ERR with start=1 SHALL go to LEN next cycle, clear word and byte counters, and set cpu_reset=1.
REQ-018 in_ready SHALL be 1 in LEN, DATA and CSUM, and 0 in all other states.
REQ-019 LEN, accepted byte N in the range 1..DEPTH_WORDS: store N and go to DATA.
REQ-020 LEN, accepted byte N=0 or N>DEPTH_WORDS: go to ERR.
REQ-021 In DATA, bytes SHALL be assembled big-endian: the first byte accepted is bits 31:24.
REQ-022 The 4th byte of a word accepted at cycle t SHALL cause WRITE at t+1, with imem_we=1, imem_a=word index (zero-extended), and imem_wd=the assembled word.
REQ-023 From WRITE, if the word index is below N-1, the block SHALL increment the index and return to DATA; otherwise it goes to CSUM (CHECKSUM_EN defined) or DONE.
REQ-024 Words SHALL be written to addresses 0..N-1 in order; the word index never wraps, and no address is at or above DEPTH_WORDS.
REQ-025 imem_we SHALL be 0 in every state except WRITE; imem_a and imem_wd hold their last values otherwise.
REQ-026 DONE SHALL set cpu_reset=0 in the same cycle that done becomes 1.
REQ-027 ERR SHALL hold cpu_reset=1.
REQ-028 in_valid=0 SHALL stall any state without timeout; partial words are kept.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 in_valid while in_ready=0 SHALL NOT consume the byte.

Reset
REQ-031 reset_n=0 SHALL asynchronously force IDLE with all counters cleared.
REQ-032 During and after reset: cpu_reset=1, in_ready=0, imem_we=0, imem_a=0, imem_wd=0, busy=0, done=0, err=0.
REQ-033 Reset mid-load SHALL abandon the load without a further imem write; the loader then waits for start.

Configuration
REQ-034 With CHECKSUM_EN defined, after the last WRITE the loader SHALL enter CSUM and accept one byte.
REQ-035 The CSUM byte SHALL be compared with the XOR of N and all 4N data bytes; a match goes to DONE and a mismatch goes to ERR.
REQ-036 Without CHECKSUM_EN, the CSUM state and the XOR register SHALL be absent, and the last WRITE goes directly to DONE.

Verification
REQ-037 start, then bytes 02, 20 08 00 05, AC 08 00 3C -> WRITE a=0 wd=0x20080005, WRITE a=1 wd=0xAC08003C, then done=1, cpu_reset=0.
REQ-038 Length byte 00, and separately length byte 21 -> ERR, err=1, cpu_reset=1, no imem_we pulse.
REQ-039 N=32 with in_valid toggling randomly -> exactly 32 writes to addresses 0..31, in_ready=0 in each WRITE cycle, then DONE.
REQ-040 reset_n low after 6 data bytes -> IDLE immediately, outputs at reset values, no further writes; a following start reloads correctly.
REQ-041 CHECKSUM_EN, N=01, word 11 22 33 44, checksum 45 -> DONE; checksum 00 -> ERR.
REQ-042 start pulsed in DONE -> LEN next cycle, cpu_reset=1, done=0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, big-endian byte stream and writes it
// as 32-bit words into instruction memory. The attached MIPS core is held in
// reset until a complete image has been loaded.
// Optional feature macro: CHECKSUM_EN adds a trailing XOR checksum byte
// (covering the length byte and all data bytes). A mismatch ends in ERR.
module imem_loader #(
   parameter int DEPTH_WORDS = 32,
   parameter int AW          = 6
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          imem_we,
   output logic [AW-1:0] imem_a,
   output logic [31:0]   imem_wd,
   output logic          cpu_reset,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_WRITE,
`ifdef CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    len_q, len_d;            // number of words N in this image
   logic [AW-1:0] idx_q, idx_d;            // index of the word being assembled
   logic [1:0]    byte_cnt_q, byte_cnt_d;  // bytes already placed in word_q
   logic [31:0]   word_q, word_d;          // big-endian shift assembly buffer
   logic [AW-1:0] imem_a_q, imem_a_d;
   logic [31:0]   imem_wd_q, imem_wd_d;
`ifdef CHECKSUM_EN
   logic [7:0]    csum_q, csum_d;          // running XOR of length and data bytes
`endif

   // Registered status outputs, decoded from the next state.
   logic in_ready_q, in_ready_d;
   logic imem_we_q, imem_we_d;
   logic cpu_reset_q, cpu_reset_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic err_q, err_d;

   logic accept;
   logic len_ok;
   logic last_word;

   assign accept    = in_valid && in_ready_q;
   assign len_ok    = (in_data != 8'd0) && (unsigned'(32'(in_data)) <= unsigned'(32'(DEPTH_WORDS)));
   assign last_word = (unsigned'(32'(idx_q)) + 32'd1) >= unsigned'(32'(len_q));

   // Next-state and datapath logic of the load sequencer.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      imem_a_d   = imem_a_q;
      imem_wd_d  = imem_wd_q;
`ifdef CHECKSUM_EN
      csum_d     = csum_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d    = S_LEN;
               idx_d      = '0;
               byte_cnt_d = '0;
               word_d     = '0;
            end
         end
         S_LEN: begin
            if (accept) begin
               len_d = in_data;
`ifdef CHECKSUM_EN
               csum_d = in_data;
`endif
               state_d = len_ok ? S_DATA : S_ERR;
            end
         end
         S_DATA: begin
            if (accept) begin
               word_d     = {word_q[23:0], in_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef CHECKSUM_EN
               csum_d = csum_q ^ in_data;
`endif
               if (byte_cnt_q == 2'd3) begin
                  state_d   = S_WRITE;
                  imem_a_d  = idx_q;
                  imem_wd_d = {word_q[23:0], in_data};
               end
            end
         end
         S_WRITE: begin
            // The index only advances when another word follows, so it never wraps.
            if (!last_word) begin
               idx_d   = idx_q + AW'(1);
               state_d = S_DATA;
            end else begin
`ifdef CHECKSUM_EN
               state_d = S_CSUM;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef CHECKSUM_EN
         S_CSUM: begin
            if (accept) begin
               state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode of the next state, so every status output is a flop.
   always_comb begin
      in_ready_d  = 1'b0;
      imem_we_d   = 1'b0;
      cpu_reset_d = 1'b1;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state_d)
         S_LEN, S_DATA: begin
            in_ready_d = 1'b1;
            busy_d     = 1'b1;
         end
`ifdef CHECKSUM_EN
         S_CSUM: begin
            in_ready_d = 1'b1;
            busy_d     = 1'b1;
         end
`endif
         S_WRITE: begin
            imem_we_d = 1'b1;
            busy_d    = 1'b1;
         end
         S_DONE: begin
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
         end
         S_ERR:   err_d = 1'b1;
         default: ;
      endcase
   end

   // State register with asynchronous reset; the core stays in reset throughout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         idx_q       <= '0;
         byte_cnt_q  <= '0;
         word_q      <= '0;
         imem_a_q    <= '0;
         imem_wd_q   <= '0;
`ifdef CHECKSUM_EN
         csum_q      <= '0;
`endif
         in_ready_q  <= 1'b0;
         imem_we_q   <= 1'b0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all flops update together from pre-edge values.
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         byte_cnt_q  <= byte_cnt_d;
         word_q      <= word_d;
         imem_a_q    <= imem_a_d;
         imem_wd_q   <= imem_wd_d;
`ifdef CHECKSUM_EN
         csum_q      <= csum_d;
`endif
         in_ready_q  <= in_ready_d;
         imem_we_q   <= imem_we_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign imem_we   = imem_we_q;
   assign imem_a    = imem_a_q;
   assign imem_wd   = imem_wd_q;
   assign cpu_reset = cpu_reset_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader. Inputs are driven and outputs sampled
// on the falling clock edge; a monitor logs every imem write.
module tb_imem_loader;

   localparam int DEPTH_WORDS = 32;
   localparam int AW          = 6;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_a;
   logic [31:0]   imem_wd;
   logic          cpu_reset;
   logic          busy;
   logic          done;
   logic          err;

   imem_loader #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .imem_we   (imem_we),
      .imem_a    (imem_a),
      .imem_wd   (imem_wd),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Status vector {cpu_reset, in_ready, imem_we, busy, done, err}.
   logic [5:0] st;
   assign st = {cpu_reset, in_ready, imem_we, busy, done, err};

   localparam logic [5:0] ST_IDLE = 6'b100000;
   localparam logic [5:0] ST_LEN  = 6'b110100;
   localparam logic [5:0] ST_DONE = 6'b000010;
   localparam logic [5:0] ST_ERR  = 6'b100001;

   int total = 0;
   int bad   = 0;

   logic [AW-1:0] wr_a [$];
   logic [31:0]   wr_d [$];
   int            ready_viol = 0;
   logic [31:0]   img [32];

   // Write monitor: one entry per imem_we pulse, and flag in_ready during WRITE.
   always @(negedge clk) begin
      if (reset_n && imem_we) begin
         wr_a.push_back(imem_a);
         wr_d.push_back(imem_wd);
         if (in_ready) ready_viol++;
      end
   end

   task automatic clear_log();
      wr_a.delete();
      wr_d.delete();
      ready_viol = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer one byte after 'gap' idle cycles; returns after it has transferred.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL byte_accept: byte %02h in_ready=%b required 1 within 50 cycles", b, in_ready);
      end
      @(negedge clk);
   endtask

   // Length byte, 4n data bytes from img[], then the checksum byte if enabled.
   task automatic load_image(input int n, input int max_gap);
      logic [7:0] b;
`ifdef CHECKSUM_EN
      logic [7:0] cs;
      cs = 8'(n);
`endif
      send_byte(8'(n), 0);
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 4; j++) begin
            b = img[i][31-8*j -: 8];
`ifdef CHECKSUM_EN
            cs = cs ^ b;
`endif
            send_byte(b, (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
         end
      end
`ifdef CHECKSUM_EN
      send_byte(cs, 0);
`endif
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      in_valid = 1'b0;
      while (!done && !err && n < 60) begin
         @(negedge clk);
         n++;
      end
      #1;
      total++;
      if (st !== ST_DONE) begin
         bad++;
         $display("FAIL %s_done: status %b required %b", name, st, ST_DONE);
      end
   endtask

   task automatic test_reset();
      reset_n  = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (st !== ST_IDLE || imem_a !== '0 || imem_wd !== 32'h0) begin
         bad++;
         $display("FAIL reset_async: status %b a=%0h wd=%08h required %b a=0 wd=0", st, imem_a, imem_wd, ST_IDLE);
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (st !== ST_IDLE || imem_a !== '0 || imem_wd !== 32'h0) begin
         bad++;
         $display("FAIL reset_after: status %b a=%0h wd=%08h required %b a=0 wd=0", st, imem_a, imem_wd, ST_IDLE);
      end
   endtask

   task automatic test_basic_load();
      clear_log();
      img[0] = 32'h2008_0005;
      img[1] = 32'hAC08_003C;
      pulse_start();
      total++;
      if (st !== ST_LEN) begin
         bad++;
         $display("FAIL basic_len: status %b required %b", st, ST_LEN);
      end
      load_image(2, 0);
      wait_done("basic");
      total++;
      if (wr_a.size() != 2) begin
         bad++;
         $display("FAIL basic_count: writes %0d required 2", wr_a.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            total++;
            if (wr_a[i] !== AW'(i) || wr_d[i] !== img[i]) begin
               bad++;
               $display("FAIL basic_write%0d: a=%0d wd=%08h required a=%0d wd=%08h", i, wr_a[i], wr_d[i], i, img[i]);
            end
         end
      end
      total++;
      if (ready_viol != 0) begin
         bad++;
         $display("FAIL basic_ready_in_write: %0d cycles with in_ready=1 required 0", ready_viol);
      end
   endtask

   task automatic test_restart_and_bad_len();
      logic [7:0] lens [2];
      lens[0] = 8'h00;
      lens[1] = 8'h21;
      clear_log();
      // Start from DONE left by the previous test.
      pulse_start();
      total++;
      if (st !== ST_LEN) begin
         bad++;
         $display("FAIL restart_from_done: status %b required %b", st, ST_LEN);
      end
      for (int k = 0; k < 2; k++) begin
         if (k != 0) pulse_start();
         send_byte(lens[k], 0);
         in_valid = 1'b0;
         repeat (3) @(negedge clk);
         total++;
         if (st !== ST_ERR || wr_a.size() != 0) begin
            bad++;
            $display("FAIL bad_len_%02h: status %b writes %0d required %b writes 0", lens[k], st, wr_a.size(), ST_ERR);
         end
      end
   endtask

   task automatic test_stall_n32();
      clear_log();
      for (int i = 0; i < 32; i++) img[i] = {8'(i), 8'(~i), 8'(i * 3), 8'hC0 | 8'(i)};
      pulse_start();
      load_image(32, 2);
      wait_done("n32");
      total++;
      if (wr_a.size() != 32) begin
         bad++;
         $display("FAIL n32_count: writes %0d required 32", wr_a.size());
      end else begin
         for (int i = 0; i < 32; i++) begin
            total++;
            if (wr_a[i] !== AW'(i) || wr_d[i] !== img[i]) begin
               bad++;
               $display("FAIL n32_write%0d: a=%0d wd=%08h required a=%0d wd=%08h", i, wr_a[i], wr_d[i], i, img[i]);
            end
         end
      end
      total++;
      if (ready_viol != 0) begin
         bad++;
         $display("FAIL n32_ready_in_write: %0d cycles with in_ready=1 required 0", ready_viol);
      end
   endtask

   task automatic test_start_while_busy();
      clear_log();
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 1);
      in_valid = 1'b0;
      pulse_start();
      total++;
      if (st !== ST_LEN) begin
         bad++;
         $display("FAIL busy_start_ignored: status %b required %b", st, ST_LEN);
      end
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
`ifdef CHECKSUM_EN
      send_byte(8'h45, 0);
`endif
      wait_done("busy_start");
      total++;
      if (wr_a.size() != 1 || wr_a[0] !== '0 || wr_d[0] !== 32'h1122_3344) begin
         bad++;
         $display("FAIL busy_start_write: writes %0d first wd=%08h required 1 write a=0 wd=11223344",
                  wr_a.size(), (wr_d.size() > 0) ? wr_d[0] : 32'h0);
      end
`ifdef CHECKSUM_EN
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      send_byte(8'h00, 0);
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (st !== ST_ERR) begin
         bad++;
         $display("FAIL csum_mismatch: status %b required %b", st, ST_ERR);
      end
`endif
   endtask

   task automatic test_reset_mid_load();
      clear_log();
      img[0] = 32'h0102_0304;
      img[1] = 32'h0506_0708;
      pulse_start();
      send_byte(8'h03, 0);
      for (int i = 0; i < 6; i++) send_byte(img[i/4][31-8*(i%4) -: 8], 0);
      total++;
      if (wr_a.size() != 1) begin
         bad++;
         $display("FAIL midload_first_write: writes %0d required 1", wr_a.size());
      end
      in_data = 8'h77;
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (st !== ST_IDLE || imem_a !== '0 || imem_wd !== 32'h0) begin
         bad++;
         $display("FAIL midload_reset_async: status %b a=%0h wd=%08h required %b a=0 wd=0", st, imem_a, imem_wd, ST_IDLE);
      end
      clear_log();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if (st !== ST_IDLE || wr_a.size() != 0) begin
         bad++;
         $display("FAIL midload_wait_start: status %b writes %0d required %b writes 0", st, wr_a.size(), ST_IDLE);
      end
      in_valid = 1'b0;
      img[0] = 32'hDEAD_BEEF;
      img[1] = 32'h0000_00FF;
      pulse_start();
      load_image(2, 1);
      wait_done("reload");
      total++;
      if (wr_a.size() != 2 || wr_a[0] !== '0 || wr_d[0] !== 32'hDEAD_BEEF ||
          wr_a[1] !== AW'(1) || wr_d[1] !== 32'h0000_00FF) begin
         bad++;
         $display("FAIL reload_writes: writes %0d required 2 writes a=0 DEADBEEF, a=1 000000FF", wr_a.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_restart_and_bad_len();
      test_stall_n32();
      test_start_while_busy();
      test_reset_mid_load();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
